// File: rtl/norm2_mul_arbiter.sv
// rtl/norm2_mul_arbiter.sv - round-robin shared 9x45 multiplier for the norm2 layer
//
// Round-robin arbiter feeding a two-stage (operand reg, product reg) multiplier
// pipeline shared by NUM_REQ requesters. Responses return in grant order.
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst_n   synchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_a      packed signed operands, requester i at [i*A_WIDTH +: A_WIDTH]
//   req_b      packed unsigned operands, same packing
//   rsp_valid  product valid (registered)
//   rsp_ready  consumer accept
//   rsp_id     index of the requester that issued the product (registered)
//   rsp_p      truncated two's complement product (registered)
//   busy       either pipeline stage holds an operation

module norm2_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 9,
  parameter int B_WIDTH  = 45,
  parameter int P_WIDTH  = 52,
  parameter int ID_WIDTH = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic                         busy
);

  // Stage 1: operand register
  logic                       r_s1_valid;
  logic signed [A_WIDTH-1:0]  r_s1_a;
  logic [B_WIDTH-1:0]         r_s1_b;
  logic [ID_WIDTH-1:0]        r_s1_id;

  // Stage 2: product register, drives the response port directly
  logic                       r_s2_valid;
  logic [P_WIDTH-1:0]         r_s2_p;
  logic [ID_WIDTH-1:0]        r_s2_id;

  // Round-robin pointer: first index scanned this cycle
  logic [ID_WIDTH-1:0]        r_ptr;

  logic                       w_s2_ready;
  logic                       w_s1_ready;
  logic                       w_found;
  logic [ID_WIDTH-1:0]        w_grant;
  logic [ID_WIDTH:0]          w_idx;
  logic                       w_accept;
  logic [ID_WIDTH-1:0]        w_next_ptr;
  logic [A_WIDTH-1:0]         w_a_sel;
  logic [B_WIDTH-1:0]         w_b_sel;
  logic signed [P_WIDTH-1:0]  w_a_ext;
  logic signed [P_WIDTH-1:0]  w_b_ext;
  logic signed [P_WIDTH-1:0]  w_prod;

  assign w_s2_ready = !r_s2_valid | rsp_ready;
  assign w_s1_ready = !r_s1_valid | w_s2_ready;

  // Scan ptr, ptr+1, ... mod NUM_REQ; the extra index bit keeps the wrap
  // correct for non-power-of-two NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_WIDTH+1)'(k);
      if (w_idx >= (ID_WIDTH+1)'(NUM_REQ)) begin
        w_idx = w_idx - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (!w_found && req_valid[w_idx[ID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[ID_WIDTH-1:0];
      end
    end
  end

  // ap_rst_n gates ready so nothing is seen as accepted while in reset.
  assign w_accept = w_found & w_s1_ready & ap_rst_n;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  assign w_next_ptr = (w_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

  // Operand mux for the granted requester
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_WIDTH'(i)) begin
        w_a_sel = req_a[i*A_WIDTH +: A_WIDTH];
        w_b_sel = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // Extending both operands to P_WIDTH before multiplying yields exactly the
  // low P_WIDTH bits of the full signed x unsigned product.
  assign w_a_ext = P_WIDTH'(r_s1_a);
  assign w_b_ext = P_WIDTH'(r_s1_b);
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_p     <= '0;
      r_s2_id    <= '0;
      r_ptr      <= '0;
    end else begin
      // S2 takes whatever S1 holds (possibly nothing) whenever it can move.
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_p  <= w_prod;
          r_s2_id <= r_s1_id;
        end
      end
      // S1 refills or empties whenever it can move; accept + transfer in the
      // same cycle keeps it full.
      if (w_s1_ready) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_a  <= w_a_sel;
          r_s1_b  <= w_b_sel;
          r_s1_id <= w_grant;
          r_ptr   <= w_next_ptr;
        end
      end
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_p     = r_s2_p;
  assign rsp_id    = r_s2_id;
  assign busy      = r_s1_valid | r_s2_valid;

endmodule
